trace_packer: RTL and testbench

- Sits directly upstream of trace_buffer and drives its din/wr pins.
- Accepts variable-length trace samples (1..Fpay valid bits, LSB-aligned) from NoC debug probes.
- Packs samples LSB-first into Fpay-wide words, with no gaps between samples. Bits that do not fit in the current word carry into the next one.
- Bounds one capture window to the trace buffer capacity and supports an explicit flush of a partial word.

---
 rtl/trace_pkg.sv | 23 ++
 rtl/trace_shift_merge.sv | 41 ++++
 rtl/trace_packer.sv | 136 +++++++++++++
 tb/tb_trace_packer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and helpers for the trace packer
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int MASK_W = 64;

  function automatic int len_width(input int fpay);
    return $clog2(fpay) + 1;
  endfunction

  // Callers truncate the result to their own word width.
  function automatic logic [MASK_W-1:0] len_mask(input int l, input int fpay);
    if (l >= fpay) return {MASK_W{1'b1}};
    return (MASK_W'(1) << l) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/trace_shift_merge.sv
// rtl/trace_shift_merge.sv - merges one masked sample into the accumulator
module trace_shift_merge
  import trace_pkg::*;
#(
  parameter int Fpay = 32,
  parameter int LENW = 6
) (
  input  logic [Fpay-1:0] acc,
  input  logic [LENW-1:0] cnt,
  input  logic [Fpay-1:0] d,
  input  logic [LENW-1:0] len,
  output logic [Fpay-1:0] next_word,
  output logic            word_valid,
  output logic [Fpay-1:0] next_acc,
  output logic [LENW-1:0] next_cnt
);
  localparam int TW = LENW + 1;

  logic [Fpay-1:0]   dm;
  logic [2*Fpay-1:0] wide;
  logic [TW-1:0]     t;
  logic [TW-1:0]     t_wrap;

  always_comb begin
    dm   = d & Fpay'(len_mask(int'(len), Fpay));
    // acc has no bits set at or above cnt, so OR-ing is a clean append.
    wide = {{Fpay{1'b0}}, acc} | ({{Fpay{1'b0}}, dm} << cnt);
    t          = {1'b0, cnt} + {1'b0, len};
    t_wrap     = t - TW'(Fpay);
    word_valid = (t >= TW'(Fpay));
    next_word  = wide[Fpay-1:0];
    if (word_valid) begin
      next_acc = wide[2*Fpay-1:Fpay];
      next_cnt = t_wrap[LENW-1:0];
    end else begin
      next_acc = wide[Fpay-1:0];
      next_cnt = t[LENW-1:0];
    end
  end

endmodule

// File: rtl/trace_packer.sv
// rtl/trace_packer.sv - packs variable-length trace samples into words for trace_buffer
module trace_packer
  import trace_pkg::*;
#(
  parameter  int Fpay      = 32,
  parameter  int MAX_WORDS = 512,
  localparam int LENW      = len_width(Fpay)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            trigger,
  input  logic [LENW-1:0] trace_len,
  input  logic [Fpay-1:0] trace_in,
  input  logic            flush,
  output logic            wr,
  output logic [Fpay-1:0] dout,
  output logic            busy,
  output logic            done,
  output logic            overflow
);
  localparam int WCW = $clog2(MAX_WORDS + 1);

  state_e          state_q, state_d;
  logic [Fpay-1:0] acc_q, acc_d, dout_q, dout_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic            wr_q, wr_d, ovf_q, ovf_d;

  logic [LENW-1:0] len_c, m_cnt;
  logic [Fpay-1:0] m_word, m_acc;
  logic            m_valid, sample, open_win;

  assign len_c    = (trace_len > LENW'(Fpay)) ? LENW'(Fpay) : trace_len;
  assign sample   = trigger && (len_c != '0);
  assign wcnt_inc = wcnt_q + WCW'(1);
  assign open_win = start && !flush;

  trace_shift_merge #(.Fpay(Fpay), .LENW(LENW)) u_merge (
    .acc        (acc_q),
    .cnt        (cnt_q),
    .d          (trace_in),
    .len        (len_c),
    .next_word  (m_word),
    .word_valid (m_valid),
    .next_acc   (m_acc),
    .next_cnt   (m_cnt)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    wr_d    = 1'b0;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (open_win) begin
          state_d = ST_ARMED;
          acc_d   = '0;
          cnt_d   = '0;
          wcnt_d  = '0;
        end
      end
      ST_ARMED: begin
        if (sample) begin
          acc_d = m_acc;
          cnt_d = m_cnt;
          if (m_valid) begin
            wr_d   = 1'b1;
            dout_d = m_word;
            wcnt_d = wcnt_inc;
          end
        end
        // Hitting the word limit beats a coincident flush and drops the residue.
        if (sample && m_valid && (wcnt_inc == WCW'(MAX_WORDS))) begin
          state_d = ST_DONE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q != '0) begin
          wr_d   = 1'b1;
          dout_d = acc_q;
          wcnt_d = wcnt_inc;
        end
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (sample) ovf_d = 1'b1;
        if (open_win) begin
          state_d = ST_ARMED;
          ovf_d   = 1'b0;
          acc_d   = '0;
          cnt_d   = '0;
          wcnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr       = wr_q;
  assign dout     = dout_q;
  assign busy     = (state_q == ST_ARMED) || (state_q == ST_FLUSH);
  assign done     = (state_q == ST_DONE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_trace_packer.sv
// tb/tb_trace_packer.sv - scoreboard bench for trace_packer
module tb_trace_packer;
  logic        clk = 1'b0;
  logic        reset, start, trigger, flush;
  logic [5:0]  trace_len;
  logic [31:0] trace_in;
  logic        wr, busy, done, overflow;
  logic [31:0] dout;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q[$];

  trace_packer #(.Fpay(32), .MAX_WORDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .trigger(trigger),
    .trace_len(trace_len), .trace_in(trace_in), .flush(flush),
    .wr(wr), .dout(dout), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_wr", dout, 32'hxxxxxxxx);
      else chk("wr_dout", dout, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    start   = 1'b0;
    trigger = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic send(input logic [5:0] len, input logic [31:0] data, input logic fl);
    trigger   = 1'b1;
    trace_len = len;
    trace_in  = data;
    flush     = fl;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; trigger = 1'b0; flush = 1'b0;
    trace_len = '0; trace_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", {31'b0, wr}, 0);
    chk("rst_dout", dout, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_ovf", {31'b0, overflow}, 0);
    @(negedge clk) reset = 1'b1;
    #1;

    // Ten-bit samples; upper garbage in the first one must be masked off.
    do_start();
    chk("armed_busy", {31'b0, busy}, 1);
    send(6'd10, 32'hFFFFF155, 1'b0);
    send(6'd10, 32'h000002AA, 1'b0);
    send(6'd0,  32'hFFFFFFFF, 1'b0);
    send(6'd10, 32'h000000F0, 1'b0);
    chk("no_wr_yet", {31'b0, wr}, 0);
    exp_q.push_back(32'hCF0AA955);
    send(6'd10, 32'h000003C3, 1'b0);
    chk("wr_after_4th", {31'b0, wr}, 1);
    exp_q.push_back(32'h000000F0);
    flush = 1'b1;
    tick();
    chk("flush_busy", {31'b0, busy}, 1);
    tick();
    chk("flush_wr", {31'b0, wr}, 1);
    chk("s1_done", {31'b0, done}, 1);
    chk("s1_busy", {31'b0, busy}, 0);

    // Full-width sample with empty accumulator; following flush writes nothing.
    do_start();
    chk("restart_done", {31'b0, done}, 0);
    exp_q.push_back(32'hDEADBEEF);
    send(6'd32, 32'hDEADBEEF, 1'b0);
    flush = 1'b1;
    tick();
    tick();
    chk("s3_done", {31'b0, done}, 1);
    tick();

    // Word limit of 4: later samples only raise overflow.
    do_start();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(32'(i));
      send(6'd32, 32'(i), 1'b0);
    end
    chk("lim_done", {31'b0, done}, 1);
    chk("lim_ovf0", {31'b0, overflow}, 0);
    send(6'd32, 32'd5, 1'b0);
    send(6'd32, 32'd6, 1'b0);
    chk("lim_ovf1", {31'b0, overflow}, 1);
    do_start();
    chk("clr_ovf", {31'b0, overflow}, 0);
    chk("clr_done", {31'b0, done}, 0);

    // cnt=28 then an 8-bit sample together with flush.
    send(6'd28, 32'h01234567, 1'b0);
    exp_q.push_back(32'hB1234567);
    exp_q.push_back(32'h0000000A);
    send(6'd8, 32'h000000AB, 1'b1);
    chk("tf_wr1", {31'b0, wr}, 1);
    tick();
    chk("tf_wr2", {31'b0, wr}, 1);
    chk("tf_done", {31'b0, done}, 1);

    // Asynchronous reset mid-window drops the partial word.
    do_start();
    send(6'd12, 32'h00000ABC, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_dout", dout, 0);
    chk("ar_wr", {31'b0, wr}, 0);
    @(negedge clk) reset = 1'b1;
    #1;
    do_start();
    exp_q.push_back(32'h12345678);
    send(6'd40, 32'h12345678, 1'b0);
    repeat (3) tick();

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
